// File: rtl/seq_bpred_update_queue_if.sv
// Stream and update-port bundle for seq_bpred_update_queue.
// Handshake: an outcome transfers on a clock edge where in_val && in_rdy; en is a one-cycle strobe with no back-pressure.
interface seq_bpred_update_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_val;
  logic          in_rdy;
  logic          in_taken;
  logic          hold;
  logic          flush;
  logic          en;
  logic          op;
  logic [CW-1:0] count;

  modport master (
    output in_val, in_taken, hold, flush,
    input  in_rdy, en, op, count
  );

  modport slave (
    input  in_val, in_taken, hold, flush,
    output in_rdy, en, op, count
  );
endinterface

// File: rtl/seq_bpred_update_queue.sv
// Circular queue of resolved-branch outcomes replayed as one en/op counter update per cycle.
// Optional macro UPDQ_BYPASS_EN: empty queue forwards an incoming outcome to en/op in the same cycle.
module seq_bpred_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  seq_bpred_update_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;

  logic             full;
  logic             empty;
  logic             rdy;
  logic             bypass;
  logic             enq;
  logic             deq;

  always_comb begin
    full  = (cnt == CW'(DEPTH));
    empty = (cnt == '0);
    rdy   = !full && !bus.flush;
`ifdef UPDQ_BYPASS_EN
    bypass = empty && bus.in_val && !bus.hold && !bus.flush;
`else
    bypass = 1'b0;
`endif
    // A bypassed outcome is consumed directly and never occupies a slot.
    enq = bus.in_val && rdy && !bypass;
    deq = !empty && !bus.hold && !bus.flush;
  end

  always_comb begin
    bus.in_rdy = rdy;
    bus.count  = cnt;
    bus.en     = deq || bypass;
    bus.op     = 1'b1;
    if (deq) begin
      bus.op = ~mem[head];
    end else if (bypass) begin
      bus.op = ~bus.in_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) begin
        tail <= tail + AW'(1);
      end
      if (deq) begin
        head <= head + AW'(1);
      end
      if (enq && !deq) begin
        cnt <= cnt + CW'(1);
      end else if (deq && !enq) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage carries no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      mem[tail] <= bus.in_taken;
    end
  end
endmodule
